// File: rtl/minimig_cpu_bridge.sv
// Bridges the 68k CPU and a set of host (UserIO/DMA-style) channels onto the
// Minimig chip bus: owner arbitration, strobe sync, wait/ack/timeout sequencing.
module minimig_cpu_bridge #(
    parameter int AW      = 23,
    parameter int NHOST   = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk7_en,
    input  logic                  clk7n_en,
    input  logic                  c1,
    input  logic                  c3,
    input  logic                  cck,
    input  logic                  dbr,
    input  logic                  dbs,
    input  logic                  nrdy,
    input  logic                  _as,
    input  logic                  _uds,
    input  logic                  _lds,
    input  logic                  r_w,
    input  logic [AW:1]           address,
    input  logic [15:0]           cpudatain,
    input  logic                  cpu_halt,
    input  logic [NHOST-1:0]      host_cs,
    input  logic [NHOST-1:0]      host_we,
    input  logic [NHOST*AW-1:0]   host_adr,
    input  logic [2*NHOST-1:0]    host_bs,
    input  logic [16*NHOST-1:0]   host_wdat,
    output logic [15:0]           host_rdat,
    output logic [NHOST-1:0]      host_ack,
    output logic                  _dtack,
    output logic                  _berr,
    output logic                  rd,
    output logic                  hwr,
    output logic                  lwr,
    output logic [AW:1]           address_out,
    output logic [15:0]           data_out,
    input  logic [15:0]           data_in,
    output logic [15:0]           data,
    output logic                  bls,
    output logic                  halted,
    output logic [1:0]            dbg_xfer_state
);

    localparam int GW = (NHOST > 1) ? $clog2(NHOST) : 1;
    localparam logic [9:0] TO_LIMIT = 10'(TIMEOUT);

    typedef enum logic {O_RUN = 1'b0, O_HOST = 1'b1} owner_t;
    typedef enum logic [1:0] {X_IDLE = 2'd0, X_WAIT = 2'd1, X_ACK = 2'd2, X_ERR = 2'd3} xfer_t;

    owner_t        owner_q, owner_d;
    xfer_t         xfer_q, xfer_d;
    logic [9:0]    cnt_q, cnt_d, cnt_inc;
    logic          aged_q, aged_d;
    logic          grant_valid_q, grant_valid_d;
    logic [GW-1:0] grant_idx_q, grant_idx_d;
    logic [GW-1:0] ptr_q, ptr_d;
    logic          strobe_q, rw_q, uds_q, lds_q;
    logic [15:0]   latch_q;

    logic          cpu_act;
    logic          sel_cs, sel_we;
    logic [1:0]    sel_bs;
    logic [AW:1]   sel_adr;
    logic [15:0]   sel_wdat;
    logic          strobe_raw, rw_raw, uds_raw, lds_raw;
    logic          pick_valid;
    logic [GW-1:0] pick_idx, pick_nxt;
    int            rr_c;
    logic          in_ack, enable;

    assign cpu_act = (owner_q == O_RUN);

    always_comb begin
        sel_cs   = 1'b0;
        sel_we   = 1'b0;
        sel_bs   = 2'b00;
        sel_adr  = '0;
        sel_wdat = '0;
        for (int i = 0; i < NHOST; i++) begin
            if (grant_idx_q == GW'(i)) begin
                sel_cs   = host_cs[i];
                sel_we   = host_we[i];
                sel_bs   = host_bs[2*i +: 2];
                sel_adr  = host_adr[i*AW +: AW];
                sel_wdat = host_wdat[16*i +: 16];
            end
        end
    end

    // Active master view; a host strobe only counts while its grant is held.
    always_comb begin
        if (cpu_act) begin
            strobe_raw = !_as;
            rw_raw     = r_w;
            uds_raw    = _uds;
            lds_raw    = _lds;
        end else begin
            strobe_raw = grant_valid_q && sel_cs;
            rw_raw     = !sel_we;
            uds_raw    = !sel_bs[1];
            lds_raw    = !sel_bs[0];
        end
    end

    // Round-robin search beginning at ptr_q; lowest offset wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        rr_c       = 0;
        for (int k = NHOST - 1; k >= 0; k--) begin
            rr_c = int'(ptr_q) + k;
            if (rr_c >= NHOST) rr_c = rr_c - NHOST;
            if (host_cs[GW'(rr_c)]) begin
                pick_valid = 1'b1;
                pick_idx   = GW'(rr_c);
            end
        end
        pick_nxt = (int'(pick_idx) == NHOST - 1) ? '0 : pick_idx + 1'b1;
    end

    always_comb begin
        owner_d       = owner_q;
        grant_valid_d = grant_valid_q;
        grant_idx_d   = grant_idx_q;
        ptr_d         = ptr_q;
        if (clk7_en && xfer_q == X_IDLE) begin
            case (owner_q)
                O_RUN:   if (cpu_halt && _as) owner_d = O_HOST;
                O_HOST:  if (!cpu_halt) owner_d = O_RUN;
                default: owner_d = O_RUN;
            endcase
        end
        if (owner_q != O_HOST) begin
            grant_valid_d = 1'b0;
        end else if (xfer_q == X_IDLE && (!grant_valid_q || !sel_cs)) begin
            grant_valid_d = pick_valid;
            if (pick_valid) begin
                grant_idx_d = pick_idx;
                ptr_d       = pick_nxt;
            end
        end
    end

    always_comb begin
        xfer_d  = xfer_q;
        cnt_d   = cnt_q;
        aged_d  = aged_q;
        cnt_inc = cnt_q + 10'd1;
        case (xfer_q)
            X_IDLE: begin
                if (clk7_en && strobe_q && strobe_raw) begin
                    xfer_d = X_WAIT;
                    cnt_d  = '0;
                end
            end
            X_WAIT: begin
                if (!strobe_raw) begin
                    xfer_d = X_IDLE;
                end else if (clk7n_en && cck && !(dbr && dbs) && !nrdy) begin
                    xfer_d = X_ACK;
                    aged_d = 1'b0;
                end else if (clk7_en) begin
                    // Host masters never time out; the counter just parks at the limit.
                    if (cnt_q != TO_LIMIT) cnt_d = cnt_inc;
                    if (cnt_inc == TO_LIMIT && cpu_act) xfer_d = X_ERR;
                end
            end
            X_ACK: begin
                if (!strobe_raw) xfer_d = X_IDLE;
                else if (clk7_en) aged_d = 1'b1;
            end
            X_ERR: begin
                if (!strobe_raw) xfer_d = X_IDLE;
            end
            default: xfer_d = X_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q       <= O_RUN;
            xfer_q        <= X_IDLE;
            cnt_q         <= '0;
            aged_q        <= 1'b0;
            grant_valid_q <= 1'b0;
            grant_idx_q   <= '0;
            ptr_q         <= '0;
            strobe_q      <= 1'b0;
            rw_q          <= 1'b1;
            uds_q         <= 1'b1;
            lds_q         <= 1'b1;
        end else begin
            owner_q       <= owner_d;
            xfer_q        <= xfer_d;
            cnt_q         <= cnt_d;
            aged_q        <= aged_d;
            grant_valid_q <= grant_valid_d;
            grant_idx_q   <= grant_idx_d;
            ptr_q         <= ptr_d;
            uds_q         <= uds_raw;
            lds_q         <= lds_raw;
            if (clk7_en) begin
                strobe_q <= strobe_raw;
                rw_q     <= rw_raw;
            end
        end
    end

    // Outputs are gated by rst so a reset mid-transfer drops them immediately.
    assign in_ack = (xfer_q == X_ACK) && !rst;
    assign enable = in_ack && aged_q && !cck && strobe_raw;

    always_ff @(posedge clk) begin
        if (rst) latch_q <= '0;
        else if (enable && !c1 && c3) latch_q <= data_in;
    end

    always_comb begin
        host_ack = '0;
        for (int i = 0; i < NHOST; i++) begin
            host_ack[i] = in_ack && !cpu_act && grant_valid_q && (grant_idx_q == GW'(i));
        end
    end

    assign rd             = enable && rw_q;
    assign hwr            = enable && !rw_q && !uds_q;
    assign lwr            = enable && !rw_q && !lds_q;
    assign _dtack         = !(in_ack && cpu_act);
    assign _berr          = !((xfer_q == X_ERR) && !rst);
    assign bls            = dbs && (xfer_q == X_WAIT) && !rst;
    assign halted         = (owner_q == O_HOST) && !rst;
    assign data           = latch_q;
    assign host_rdat      = latch_q;
    assign data_out       = cpu_act ? cpudatain : sel_wdat;
    assign address_out    = cpu_act ? address : sel_adr;
    assign dbg_xfer_state = xfer_q;

endmodule
